bsg_mem_1rw_sync_mask_write_bit_segmented_init: RTL

Segmented single-port synchronous SRAM wrapper with per-segment valids, bit-masked writes, per-segment read-valid outputs and a built-in post-reset initialization sequencer that fills every entry with a constant. It sits wherever a segmented masked memory must come out of reset in a known state, such as tag/state arrays or directories, without an external clear pass. It generalises the segmented mask-write memory with a hardware init FSM, a ready handshake, per-segment `v_o` and per-segment latch-last-read.

---
 rtl/bsg_mem_1rw_sync_mask_write_bit_segmented_init.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/bsg_mem_1rw_sync_mask_write_bit_segmented_init.sv
// -----------------------------------------------------------------------------
// bsg_mem_1rw_sync_mask_write_bit_segmented_init
//
// Single-port synchronous memory split into num_segments_p segments. Each
// segment is enabled on its own, and writes use a per-bit mask. After reset
// deasserts, a small sequencer writes init_val_p to every entry before the
// memory accepts requests.
//
// Ports:
//   clk_i     - clock
//   reset_i   - asynchronous, active-high reset
//   v_i       - per-segment request enable
//   w_i       - 1 = write, 0 = read (applies to all enabled segments)
//   addr_i    - entry address
//   data_i    - write data, segment i at [i*sw +: sw]
//   w_mask_i  - per-bit write mask, 1 = write the bit
//   ready_o   - 1 when requests are accepted (low during reset and init)
//   v_o       - per-segment read-data valid, one cycle after an accepted read
//   data_o    - read data
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module bsg_mem_1rw_sync_mask_write_bit_segmented_init #(
  parameter int                 width_p           = 32,
  parameter int                 els_p             = 16,
  parameter int                 num_segments_p    = 4,
  parameter int                 latch_last_read_p = 0,
  parameter logic [width_p-1:0] init_val_p        = '0,
  localparam int                addr_width_lp     = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [num_segments_p-1:0] v_i,
  input  logic                      w_i,
  input  logic [addr_width_lp-1:0]  addr_i,
  input  logic [width_p-1:0]        data_i,
  input  logic [width_p-1:0]        w_mask_i,
  output logic                      ready_o,
  output logic [num_segments_p-1:0] v_o,
  output logic [width_p-1:0]        data_o
);

  localparam int                     seg_width_lp = width_p / num_segments_p;
  localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_INIT  = 2'd1,
    ST_READY = 2'd2
  } state_e;

  state_e                     r_state, w_state_next;
  logic [addr_width_lp-1:0]   r_count, w_count_next;

  // ---------------------------------------------------------------------------
  // Init sequencer. RESET is held while reset_i is high; the first edge after
  // release enters INIT, which then spends exactly els_p cycles writing
  // entries 0..els_p-1 before handing over to READY.
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    unique case (r_state)
      ST_RESET: begin
        w_state_next = ST_INIT;
        w_count_next = '0;
      end
      ST_INIT: begin
        // Stop on the last real entry so non-power-of-two depths never
        // touch the unused addresses.
        if (r_count == last_addr_lp) begin
          w_state_next = ST_READY;
        end else begin
          w_count_next = r_count + 1'b1;
        end
      end
      ST_READY: w_state_next = ST_READY;
      default:  w_state_next = ST_RESET;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= ST_RESET;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

  assign ready_o = (r_state == ST_READY);

  // ---------------------------------------------------------------------------
  // Write port: the init fill and accepted user writes share one path. Segment
  // enables are folded into a full-width bit mask.
  // ---------------------------------------------------------------------------
  logic                     w_req;
  logic                     w_rd;
  logic                     w_wr_en;
  logic [addr_width_lp-1:0] w_wr_addr;
  logic [width_p-1:0]       w_wr_data;
  logic [width_p-1:0]       w_wr_mask;

  assign w_req = ready_o & (|v_i);
  assign w_rd  = w_req & ~w_i;

  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = addr_i;
    w_wr_data = data_i;
    w_wr_mask = '0;
    if (r_state == ST_INIT) begin
      w_wr_en   = 1'b1;
      w_wr_addr = r_count;
      w_wr_data = init_val_p;
      w_wr_mask = '1;
    end else if (w_req && w_i) begin
      w_wr_en = 1'b1;
      for (int s = 0; s < num_segments_p; s++) begin
        w_wr_mask[s*seg_width_lp +: seg_width_lp] =
          v_i[s] ? w_mask_i[s*seg_width_lp +: seg_width_lp] : '0;
      end
    end
  end

  // NOTE: the storage array has no reset; its contents are defined by the
  // init sequencer, which keeps the array mappable onto plain SRAM macros.
  logic [width_p-1:0] r_mem [els_p];

  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= (r_mem[w_wr_addr] & ~w_wr_mask) | (w_wr_data & w_wr_mask);
    end
  end

  // ---------------------------------------------------------------------------
  // Read port. With latch_last_read_p the unread segments keep their previous
  // value; otherwise the whole word is loaded on any read since unread
  // segments are don't-care and a single enable is cheaper.
  // ---------------------------------------------------------------------------
  logic [num_segments_p-1:0] w_rd_seg_en;
  logic [num_segments_p-1:0] r_v_o;
  logic [width_p-1:0]        r_data_o;

  assign w_rd_seg_en = (latch_last_read_p != 0) ? v_i : '1;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_v_o    <= '0;
      r_data_o <= '0;
    end else begin
      r_v_o <= w_rd ? v_i : '0;
      if (w_rd) begin
        for (int s = 0; s < num_segments_p; s++) begin
          if (w_rd_seg_en[s]) begin
            r_data_o[s*seg_width_lp +: seg_width_lp] <=
              r_mem[addr_i][s*seg_width_lp +: seg_width_lp];
          end
        end
      end
    end
  end

  assign v_o    = r_v_o;
  assign data_o = r_data_o;

endmodule
